// File: rtl/nios_system_led_pwm.sv
// LED PWM / blink stage behind the 8-bit LED PIO.
// Avalon-MM slave holds BRIGHT/BLINK/CTRL; pattern and brightness are
// shadowed on PWM frame boundaries so LEDs never change mid-frame.
`timescale 1ns/1ps
module nios_system_led_pwm #(
  parameter int unsigned PRESCALE   = 195,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pattern_in,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  led
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  bright_q, bright_d;
  logic [15:0] blink_q, blink_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [7:0]  pat_sh_q, pat_sh_d;
  logic [7:0]  bri_sh_q, bri_sh_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic [7:0]  led_q, led_d;

  logic tick;
  logic frame_start;
  logic wr_en;
  logic unused_wdata;

  assign tick        = (pre_cnt_q == PRESCALE_W'(PRESCALE - 1));
  assign frame_start = tick & (pwm_cnt_q == 8'hFF);
  assign wr_en       = chipselect & ~write_n;
  assign unused_wdata = ^writedata[31:16];
  assign led         = led_q;

  // Register read mux: purely combinational on address, no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {24'h0, bright_q};
      2'd1: readdata = {16'h0, blink_q};
      2'd2: readdata = {30'h0, ctrl_q};
      2'd3: readdata = {blink_cnt_q, 7'h0, blink_phase_q, pwm_cnt_q};
      default: readdata = '0;
    endcase
  end

  // Next-state: bus writes, prescaler/PWM counters, frame shadows, blink, LED drive.
  always_comb begin
    bright_d      = bright_q;
    blink_d       = blink_q;
    ctrl_d        = ctrl_q;
    pre_cnt_d     = pre_cnt_q;
    pwm_cnt_d     = pwm_cnt_q;
    pat_sh_d      = pat_sh_q;
    bri_sh_d      = bri_sh_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;

    if (wr_en) begin
      case (address)
        2'd0: bright_d = writedata[7:0];
        2'd1: blink_d  = writedata[15:0];
        2'd2: ctrl_d   = writedata[1:0];
        default: ;
      endcase
    end

    pre_cnt_d = tick ? '0 : pre_cnt_q + PRESCALE_W'(1);
    if (tick) pwm_cnt_d = pwm_cnt_q + 8'd1;

    // Shadows and blink use the pre-write register values, so a write in
    // the frame_start clock only affects the following frame.
    if (frame_start) begin
      pat_sh_d = pattern_in;
      bri_sh_d = bright_q;
    end

    if (blink_q == 16'h0) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q >= blink_q - 16'd1) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    led_d = pat_sh_q & {8{ctrl_q[0] & blink_phase_q &
                          (ctrl_q[1] | (pwm_cnt_q < bri_sh_q))}};
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      bright_q      <= 8'hFF;
      blink_q       <= '0;
      ctrl_q        <= '0;
      pat_sh_q      <= '0;
      bri_sh_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      led_q         <= '0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      bright_q      <= bright_d;
      blink_q       <= blink_d;
      ctrl_q        <= ctrl_d;
      pat_sh_q      <= pat_sh_d;
      bri_sh_q      <= bri_sh_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      led_q         <= led_d;
    end
  end

endmodule
